// File: rtl/argmax_pkg.sv
// Shared types and defaults for the streaming argmax block.
// Holds the FSM state encoding and default sizing.
package argmax_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int POS_W_DEF  = 4;
   localparam int N_DEF      = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/argmax_cmp.sv
// Signed max-of-two with position select.
// Operand a is the incumbent and wins on a tie.
module argmax_cmp #(
   parameter int DATA_W = 16,
   parameter int POS_W  = 4
) (
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic        [POS_W-1:0]  pos_a,
   input  logic        [POS_W-1:0]  pos_b,
   output logic        [POS_W-1:0]  pos_max,
   output logic signed [DATA_W-1:0] max_val
);

   logic b_gt;

   // b replaces a only when strictly greater
   always_comb begin
      b_gt    = (b > a);
      pos_max = b_gt ? pos_b : pos_a;
      max_val = b_gt ? b : a;
   end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax: finds the largest signed sample of a vector
// and reports its value and index through a valid/ready result port.
module argmax_stream
   import argmax_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int POS_W  = POS_W_DEF,
   parameter int N      = N_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [POS_W:0]    len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [POS_W-1:0]  out_pos,
   output logic [DATA_W-1:0] out_max,
   output logic              busy
);

   localparam logic [POS_W:0] N_L   = (POS_W+1)'(N);
   localparam logic [POS_W:0] ONE_L = (POS_W+1)'(1);

   state_e              state_q, state_d;
   logic [POS_W-1:0]    idx_q, idx_d;
   logic [POS_W:0]      len_q, len_d;
   logic [DATA_W-1:0]   max_q, max_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;
   logic [POS_W-1:0]    out_pos_q, out_pos_d;
   logic [DATA_W-1:0]   out_max_q, out_max_d;

   logic                take;
   logic                last;
   logic [POS_W-1:0]    cmp_pos;
   logic [DATA_W-1:0]   cmp_max;
   logic [POS_W-1:0]    sel_pos;
   logic [DATA_W-1:0]   sel_max;

   argmax_cmp #(
      .DATA_W (DATA_W),
      .POS_W  (POS_W)
   ) u_cmp (
      .a       (max_q),
      .b       (in_data),
      .pos_a   (pos_q),
      .pos_b   (idx_q),
      .pos_max (cmp_pos),
      .max_val (cmp_max)
   );

   // Next-state, running max and registered output values
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      max_d       = max_q;
      pos_d       = pos_q;
      out_pos_d   = out_pos_q;
      out_max_d   = out_max_q;
      take        = in_valid && in_ready_q;
      last        = ({1'b0, idx_q} == (len_q - ONE_L));
      sel_max     = (idx_q == '0) ? in_data : cmp_max;
      sel_pos     = (idx_q == '0) ? '0 : cmp_pos;
      unique case (state_q)
         S_IDLE: begin
            if (start && (len != '0)) begin
               state_d = S_ACCUM;
               len_d   = (len > N_L) ? N_L : len;
               idx_d   = '0;
            end
         end
         S_ACCUM: begin
            if (take) begin
               max_d = sel_max;
               pos_d = sel_pos;
               if (last) begin
                  state_d   = S_DONE;
                  out_max_d = sel_max;
                  out_pos_d = sel_pos;
               end else begin
                  idx_d = idx_q + POS_W'(1);
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d  = (state_d == S_ACCUM);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   // State and output registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         len_q       <= '0;
         max_q       <= '0;
         pos_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         out_pos_q   <= '0;
         out_max_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         max_q       <= max_d;
         pos_q       <= pos_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         out_pos_q   <= out_pos_d;
         out_max_q   <= out_max_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_pos   = out_pos_q;
   assign out_max   = out_max_q;

endmodule

// File: tb/tb_argmax_stream.sv
// Directed testbench for argmax_stream.
// Each scenario task drives stimulus and checks inline.
module tb_argmax_stream;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [4:0]  len;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_pos;
   logic [15:0] out_max;
   logic        busy;

   int nvec;
   int nerr;
   logic [15:0] smp [0:31];
   logic        early;

   argmax_stream dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pos   (out_pos),
      .out_max   (out_max),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
      smp[0] = a;
      smp[1] = b;
      smp[2] = c;
      smp[3] = d;
   endtask

   task automatic start_vec(input logic [4:0] l);
      start = 1'b1;
      len   = l;
      cyc();
      start = 1'b0;
      len   = '0;
   endtask

   // Feeds n samples from smp; returns right after the last accept edge.
   task automatic feed(input int n, input bit bubbles);
      int i;
      int budget;
      bit acc;
      i      = 0;
      budget = 0;
      early  = 1'b0;
      while (i < n && budget < 300) begin
         in_valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_data  = smp[i];
         if (out_valid) early = 1'b1;
         acc = in_valid && in_ready;
         cyc();
         if (acc) i++;
         budget++;
      end
      in_valid = 1'b0;
      in_data  = '0;
      nvec++;
      if (i != n) begin
         $display("FAIL feed_timeout: accepted %0d of %0d", i, n);
         nerr++;
      end
   endtask

   task automatic check_result(input string nm, input logic [3:0] ep,
                               input logic [15:0] em);
      nvec++;
      if ({early, out_valid, out_pos, out_max} !== {1'b0, 1'b1, ep, em}) begin
         $display("FAIL %s: early=%0b valid=%0b pos=%0d max=%h, want 0 1 %0d %h",
                  nm, early, out_valid, out_pos, out_max, ep, em);
         nerr++;
      end
   endtask

   task automatic drain(input string nm);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      nvec++;
      if ({out_valid, busy, in_ready} !== 3'b000) begin
         $display("FAIL %s_drain: valid=%0b busy=%0b in_ready=%0b, want 000",
                  nm, out_valid, busy, in_ready);
         nerr++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc();
      nvec++;
      if ({in_ready, out_valid, busy, out_pos, out_max} !== 23'd0) begin
         $display("FAIL reset_state: rdy=%0b val=%0b busy=%0b pos=%0d max=%h, want 0",
                  in_ready, out_valid, busy, out_pos, out_max);
         nerr++;
      end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_descending();
      set4(16'd5, 16'd4, 16'd3, 16'd2);
      start_vec(5'd4);
      feed(4, 1'b0);
      check_result("desc", 4'd0, 16'd5);
      drain("desc");
   endtask

   task automatic test_signed();
      set4(-16'sd5, 16'sd4, -16'sd3, 16'sd7);
      start_vec(5'd4);
      feed(4, 1'b0);
      check_result("mixed", 4'd3, 16'd7);
      drain("mixed");
      set4(-16'sd8, -16'sd2, -16'sd9, -16'sd2);
      start_vec(5'd4);
      feed(4, 1'b0);
      check_result("neg_tie", 4'd1, 16'hFFFE);
      drain("neg_tie");
   endtask

   task automatic test_len_edge();
      smp[0] = 16'h8000;
      start_vec(5'd1);
      feed(1, 1'b0);
      check_result("len1_min", 4'd0, 16'h8000);
      drain("len1");
      start_vec(5'd0);
      for (int k = 0; k < 3; k++) begin
         nvec++;
         if ({busy, out_valid, in_ready} !== 3'b000) begin
            $display("FAIL len0_idle: busy=%0b valid=%0b rdy=%0b, want 000",
                     busy, out_valid, in_ready);
            nerr++;
         end
         cyc();
      end
      nvec++;
      if ({out_pos, out_max} !== {4'd0, 16'h8000}) begin
         $display("FAIL idle_retain: pos=%0d max=%h, want 0 8000",
                  out_pos, out_max);
         nerr++;
      end
   endtask

   task automatic test_bubbles();
      for (int k = 0; k < 16; k++) smp[k] = 16'(k * 3 - 20);
      smp[15] = 16'd100;
      start_vec(5'd16);
      feed(16, 1'b1);
      check_result("len16_bub", 4'd15, 16'd100);
      drain("len16");
   endtask

   task automatic test_len_clamp();
      for (int k = 0; k < 20; k++) smp[k] = 16'(k);
      smp[7]  = 16'd50;
      smp[16] = 16'd900;
      start_vec(5'd20);
      feed(16, 1'b0);
      nvec++;
      if (in_ready !== 1'b0) begin
         $display("FAIL len20_rdy: in_ready=%0b, want 0", in_ready);
         nerr++;
      end
      check_result("len20", 4'd7, 16'd50);
      in_valid = 1'b1;
      in_data  = 16'd900;
      cyc();
      cyc();
      in_valid = 1'b0;
      nvec++;
      if ({out_valid, out_pos, out_max} !== {1'b1, 4'd7, 16'd50}) begin
         $display("FAIL len20_extra: val=%0b pos=%0d max=%h, want 1 7 0032",
                  out_valid, out_pos, out_max);
         nerr++;
      end
      drain("len20");
   endtask

   task automatic test_hold();
      smp[0] = 16'd3;
      smp[1] = 16'hFFFF;
      start_vec(5'd2);
      feed(2, 1'b0);
      check_result("hold_res", 4'd0, 16'd3);
      start = 1'b1;
      len   = 5'd3;
      for (int k = 0; k < 10; k++) begin
         cyc();
         nvec++;
         if ({out_valid, busy, in_ready, out_pos, out_max} !==
             {3'b110, 4'd0, 16'd3}) begin
            $display("FAIL hold_c%0d: val=%0b busy=%0b rdy=%0b pos=%0d max=%h",
                     k, out_valid, busy, in_ready, out_pos, out_max);
            nerr++;
         end
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      start = 1'b0;
      len   = '0;
      nvec++;
      if ({out_valid, busy} !== 2'b00) begin
         $display("FAIL hold_release: val=%0b busy=%0b, want 00",
                  out_valid, busy);
         nerr++;
      end
      cyc();
      nvec++;
      if (busy !== 1'b0) begin
         $display("FAIL no_same_cycle_restart: busy=%0b, want 0", busy);
         nerr++;
      end
   endtask

   task automatic test_reset_mid();
      set4(16'd10, 16'd20, 16'd30, 16'd40);
      start_vec(5'd4);
      feed(2, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      nvec++;
      if ({in_ready, out_valid, busy, out_pos, out_max} !== 23'd0) begin
         $display("FAIL async_reset: rdy=%0b val=%0b busy=%0b pos=%0d max=%h",
                  in_ready, out_valid, busy, out_pos, out_max);
         nerr++;
      end
      cyc();
      rst_n = 1'b1;
      cyc();
      smp[0] = 16'd1;
      smp[1] = 16'd9;
      start_vec(5'd2);
      feed(2, 1'b0);
      check_result("post_reset", 4'd1, 16'd9);
      drain("post_reset");
   endtask

   initial begin
      nvec      = 0;
      nerr      = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_descending();
      test_signed();
      test_len_edge();
      test_bubbles();
      test_len_clamp();
      test_hold();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
